// File: rtl/multicycle_controller.sv
// Multicycle ARM control FSM: decodes the IR, sequences the datapath, owns NZCV and condition gating.
// Latency: one state per cycle, no wait states (CPI DP=4, LDR=5, STR=4, B=3, Op=11 NOP=2); no backpressure.
// Optional feature macro COND_EXEC_EN: when defined, Cond is evaluated against NZCV; otherwise every instruction executes.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    output logic         PCWrite,
    output logic         AdrSrc,
    output logic         MemWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   ALUSrcA,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUControl
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 0,
        S_DECODE = 1,
        S_MEMADR = 2,
        S_MEMRD  = 3,
        S_MEMWB  = 4,
        S_MEMWR  = 5,
        S_EXECR  = 6,
        S_EXECI  = 7,
        S_ALUWB  = 8,
        S_BRANCH = 9,
        S_SPARE  = 10
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  flags_q, flags_d;
    logic        condex_q, condex_d;

    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic        unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign unused_rn = ^Instr[19:16];

    // ALU command decode; only EXECR/EXECI drive ALUControl from it
    logic [1:0]  alu_op;
    logic        alu_known;
    logic        alu_arith;
    logic        is_cmp;
    logic [1:0]  flag_w;

    always_comb begin
        alu_op    = 2'b00;
        alu_known = 1'b1;
        alu_arith = 1'b0;
        case (funct[4:1])
            4'b0100: begin alu_op = 2'b00; alu_arith = 1'b1; end
            4'b0010: begin alu_op = 2'b01; alu_arith = 1'b1; end
            4'b0000: alu_op = 2'b10;
            4'b1100: alu_op = 2'b11;
            4'b1010: begin alu_op = 2'b01; alu_arith = 1'b1; end
            default: alu_known = 1'b0;
        endcase
    end

    // NoWrite must stay asserted through ALUWB, so it is not tied to the EXEC states
    assign is_cmp = (op == 2'b00) && (funct[4:1] == 4'b1010);

    always_comb begin
        flag_w = 2'b00;
        if (is_cmp) begin
            flag_w = 2'b11;
        end else if (alu_known && funct[0]) begin
            flag_w = {1'b1, alu_arith};
        end
    end

    logic cond_ex;
`ifdef COND_EXEC_EN
    logic fn, fz, fc, fv;
    assign {fn, fz, fc, fv} = flags_q;
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            4'b0000: cond_ex = fz;
            4'b0001: cond_ex = ~fz;
            4'b0010: cond_ex = fc;
            4'b0011: cond_ex = ~fc;
            4'b0100: cond_ex = fn;
            4'b0101: cond_ex = ~fn;
            4'b0110: cond_ex = fv;
            4'b0111: cond_ex = ~fv;
            4'b1000: cond_ex = fc & ~fz;
            4'b1001: cond_ex = ~fc | fz;
            4'b1010: cond_ex = (fn == fv);
            4'b1011: cond_ex = (fn != fv);
            4'b1100: cond_ex = ~fz & (fn == fv);
            4'b1101: cond_ex = fz | (fn != fv);
            default: cond_ex = 1'b1;
        endcase
    end
`else
    logic unused_cond;
    assign unused_cond = ^cond;
    assign cond_ex     = 1'b1;
`endif

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_EXECR:  state_d = S_ALUWB;
            S_EXECI:  state_d = S_ALUWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        flags_d = flags_q;
        if (((state_q == S_EXECR) || (state_q == S_EXECI)) && condex_q) begin
            if (flag_w[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    assign condex_d = (state_q == S_DECODE) ? cond_ex : condex_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_FETCH;
            flags_q  <= 4'b0000;
            condex_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            flags_q  <= flags_d;
            condex_q <= condex_d;
        end
    end

    logic reg_w, mem_w, branch;

    always_comb begin
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        branch     = 1'b0;
        IRWrite    = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (state_q)
            S_FETCH: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_DECODE: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                reg_w     = 1'b1;
            end
            S_MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
            end
            S_EXECR:  ALUControl = alu_op;
            S_EXECI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_op;
            end
            S_ALUWB:  reg_w = 1'b1;
            S_BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    // Every architectural write is gated by the condition latched in DECODE
    assign RegWrite = reg_w & condex_q & ~is_cmp;
    assign MemWrite = mem_w & condex_q;
    assign PCWrite  = (state_q == S_FETCH) | (branch & condex_q) | (RegWrite & (rd == 4'd15));
    assign RegSrc   = {(op == 2'b01), (state_q == S_BRANCH)};
    assign ImmSrc   = op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed and random instruction streams for multicycle_controller, checked per cycle against an instruction-level model.
module tb_multicycle_controller;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       memw;
        logic       irw;
        logic       regw;
        logic [1:0] regsrc;
        logic [1:0] immsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] ressrc;
        logic [1:0] aluctl;
    } ctl_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0]   RegSrc, ImmSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl;
    ctl_t         obs;

    int           n_asserts = 0;
    int           n_fail    = 0;
    logic [3:0]   mflags    = 4'b0000;
    ctl_t         exp_q[$];
    int           ins_idx   = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .Instr      (Instr),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .RegSrc     (RegSrc),
        .ImmSrc     (ImmSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl)
    );

    always #5 clk = ~clk;

    assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, RegSrc, ImmSrc,
                  ALUSrcA, ALUSrcB, ResultSrc, ALUControl};

    function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v, r;
        {n, z, cy, v} = f;
        case (c)
            4'h0: r = z;
            4'h1: r = !z;
            4'h2: r = cy;
            4'h3: r = !cy;
            4'h4: r = n;
            4'h5: r = !n;
            4'h6: r = v;
            4'h7: r = !v;
            4'h8: r = cy && !z;
            4'h9: r = !cy || z;
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = !z && (n == v);
            4'hD: r = z || (n != v);
            default: r = 1'b1;
        endcase
`ifndef COND_EXEC_EN
        r = 1'b1;
`endif
        return r;
    endfunction

    task automatic check_ctl(input string tag, input ctl_t o, input ctl_t e);
        n_asserts++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic check_flags(input string tag);
        n_asserts++;
        assert (dut.flags_q === mflags) else begin
            n_fail++;
            $error("FAIL %s flags observed=%b expected=%b", tag, dut.flags_q, mflags);
        end
    endtask

    // Instruction-level model: expected control vector for each cycle, plus the flag effect
    task automatic model(input logic [19:0] ins, input logic [3:0] aluf);
        logic [3:0] cond, rd;
        logic [1:0] op, aluc;
        logic [5:0] funct;
        logic       pass, cmp, known, arith;
        ctl_t       base, c;
        cond  = ins[19:16];
        op    = ins[15:14];
        funct = ins[13:8];
        rd    = ins[3:0];
        pass  = cond_ok(cond, mflags);
        exp_q.delete();
        base = '0;
        base.immsrc    = op;
        base.regsrc[1] = (op == 2'b01);
        c = base; c.pcw = 1'b1; c.irw = 1'b1; c.srca = 2'd1; c.srcb = 2'd2; c.ressrc = 2'd2;
        exp_q.push_back(c);
        c = base; c.srca = 2'd1; c.srcb = 2'd2; c.ressrc = 2'd2;
        exp_q.push_back(c);
        case (op)
            2'b00: begin
                cmp = 1'b0; known = 1'b1; arith = 1'b0; aluc = 2'd0;
                case (funct[4:1])
                    4'b0100: begin aluc = 2'd0; arith = 1'b1; end
                    4'b0010: begin aluc = 2'd1; arith = 1'b1; end
                    4'b0000: aluc = 2'd2;
                    4'b1100: aluc = 2'd3;
                    4'b1010: begin aluc = 2'd1; arith = 1'b1; cmp = 1'b1; end
                    default: known = 1'b0;
                endcase
                c = base; c.srcb = funct[5] ? 2'd1 : 2'd0; c.aluctl = aluc;
                exp_q.push_back(c);
                c = base; c.regw = pass && !cmp; c.pcw = c.regw && (rd == 4'd15);
                exp_q.push_back(c);
                if (pass) begin
                    if (cmp) begin
                        mflags = aluf;
                    end else if (known && funct[0]) begin
                        mflags[3:2] = aluf[3:2];
                        if (arith) mflags[1:0] = aluf[1:0];
                    end
                end
            end
            2'b01: begin
                c = base; c.srcb = 2'd1;
                exp_q.push_back(c);
                if (funct[0]) begin
                    c = base; c.adr = 1'b1;
                    exp_q.push_back(c);
                    c = base; c.ressrc = 2'd1; c.regw = pass; c.pcw = pass && (rd == 4'd15);
                    exp_q.push_back(c);
                end else begin
                    c = base; c.adr = 1'b1; c.memw = pass;
                    exp_q.push_back(c);
                end
            end
            2'b10: begin
                c = base; c.regsrc[0] = 1'b1; c.srca = 2'd2; c.srcb = 2'd1;
                c.ressrc = 2'd2; c.pcw = pass;
                exp_q.push_back(c);
            end
            default: ;
        endcase
    endtask

    // Entered and left one time unit after a rising edge with the DUT in FETCH
    task automatic run_instr(input logic [19:0] ins, input logic [3:0] aluf, input int stop_at);
        int n;
        Instr    = ins;
        ALUFlags = aluf;
        model(ins, aluf);
        n = (stop_at < 0) ? exp_q.size() : stop_at;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_ctl($sformatf("ins%0d_%05h_cyc%0d", ins_idx, ins, k), obs, exp_q[k]);
            @(posedge clk);
            #1;
        end
        if (stop_at < 0) check_flags($sformatf("ins%0d_%05h_flags", ins_idx, ins));
        ins_idx++;
    endtask

    initial begin
        logic [19:0] rins;
        logic [3:0]  cmds[5];
        cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010;

        reset    = 1'b0;
        Instr    = 20'h00000;
        ALUFlags = 4'b0000;
        model(20'h00000, 4'b0000);
        #3;
        check_ctl("reset_outputs", obs, exp_q[0]);
        check_flags("reset_flags");
        @(posedge clk);
        #1;
        check_ctl("reset_held", obs, exp_q[0]);
        reset = 1'b1;

        run_instr(20'hE2821, 4'b1111, -1);   // ADD R1,R2,#5
        run_instr(20'hE5912, 4'b0000, -1);   // LDR R2,[R1,#4]
        run_instr(20'hE5812, 4'b0000, -1);   // STR R2,[R1,#4]
        run_instr(20'hE0500, 4'b0100, -1);   // SUBS R0,R0,R0 -> Z
        run_instr(20'h0A000, 4'b0000, -1);   // BEQ
        run_instr(20'h1A000, 4'b0000, -1);   // BNE
        run_instr(20'h00900, 4'b0000, -1);   // ADDSEQ clears Z, still writes
        run_instr(20'hE3500, 4'b1001, -1);   // CMP R0,#1
        run_instr(20'hE281F, 4'b0000, -1);   // ADD PC,R1,#imm
        run_instr(20'hE591F, 4'b0000, -1);   // LDR PC
        run_instr(20'hEC000, 4'b0000, -1);   // Op=11 NOP

        // Asynchronous reset in the middle of MEMRD
        run_instr(20'hE5912, 4'b0000, 3);
        reset = 1'b0;
        #1;
        check_ctl("reset_mid_memrd", obs, exp_q[0]);
        mflags = 4'b0000;
        check_flags("reset_mid_memrd_flags");
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_instr(20'hE2821, 4'b0000, -1);

        for (int i = 0; i < 300; i++) begin
            rins = 20'($urandom);
            if (rins[15:14] == 2'b00 && $urandom_range(0, 1) == 1)
                rins[12:9] = cmds[$urandom_range(0, 4)];
            run_instr(rins, 4'($urandom_range(0, 15)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
